// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   muldiv_op_t    : operation code, RV32M/RV64M funct3 encoding
//   muldiv_state_t : control FSM states
//   helpers        : operand signedness and operation class decode
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // MUL returns only the low half, which is sign-agnostic, so it is
  // treated as unsigned.
  function automatic logic is_signed_op1(muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_op2(muldiv_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_div_op(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_high_op(muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in       : current partial remainder (XLEN+1 bits)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    // The remainder stays below the divisor, so XLEN+1 bits always hold it.
    rem_out = q_bit ? (XLEN+1)'(shifted - {2'b00, divisor}) : shifted[XLEN:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the eight RV32M/RV64M operations.
// Multiply is radix-2 shift-add, divide is restoring, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single
// cycle through a hardware multiplier; division is unchanged.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready high only in IDLE)
//   op, op1_data, op2_data : operation and operands
//   kill                : pipeline flush, drops any in-flight operation
//   out_valid / out_ready : result handshake
//   result              : registered result, stable while out_valid
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | iterating one bit per cycle, counter counts down to 0
// DONE  | result presented, waiting for out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] op1_data,
  input  logic [XLEN-1:0] op2_data,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

  muldiv_state_t state, state_next;

  muldiv_op_t      op_q;
  logic            neg_q;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;     // product accumulator; low half is the quotient when dividing
  logic [XLEN-1:0] mcand;     // multiplicand or divisor magnitude
  logic [XLEN:0]   prem;      // partial remainder
  logic [XLEN-1:0] result_q;

  // Accept-side decode
  logic            accept;
  logic            op1_neg, op2_neg, res_neg;
  logic [XLEN-1:0] op1_mag, op2_mag;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_mul;
  logic [XLEN-1:0] fast_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rem_next;
  logic              div_q_bit;
  logic [XLEN-1:0]   q_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   busy_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign accept    = (state == IDLE) && in_valid && !kill;

  always_comb begin
    op1_neg     = is_signed_op1(op) & op1_data[XLEN-1];
    op2_neg     = is_signed_op2(op) & op2_data[XLEN-1];
    op1_mag     = op1_neg ? -op1_data : op1_data;
    op2_mag     = op2_neg ? -op2_data : op2_data;
    res_neg     = is_rem_op(op) ? op1_neg : (op1_neg ^ op2_neg);
    div_by_zero = (op2_data == '0);
    div_ovf     = ((op == DIV) || (op == REM))
                  && (op1_data == {1'b1, {(XLEN-1){1'b0}}})
                  && (&op2_data);
    special     = is_div_op(op) && (div_by_zero || div_ovf);
    if (div_by_zero)
      special_res = is_rem_op(op) ? op1_data : '1;
    else
      special_res = is_rem_op(op) ? '0 : op1_data;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_prod;

  always_comb begin
    fm_a     = {is_signed_op1(op) & op1_data[XLEN-1], op1_data};
    fm_b     = {is_signed_op2(op) & op2_data[XLEN-1], op2_data};
    fm_prod  = fm_a * fm_b;
    fast_mul = !is_div_op(op);
    fast_res = is_high_op(op) ? XLEN'(fm_prod >>> XLEN) : XLEN'(fm_prod);
  end
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (prem),
    .dividend_bit (acc[XLEN-1]),
    .divisor      (mcand),
    .rem_out      (div_rem_next),
    .q_bit        (div_q_bit)
  );

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : '0)};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    q_next   = {acc[XLEN-2:0], div_q_bit};
    prod_fix = neg_q ? -mul_next : mul_next;
    quo_fix  = neg_q ? -q_next : q_next;
    rem_fix  = neg_q ? -div_rem_next[XLEN-1:0] : div_rem_next[XLEN-1:0];
    if (is_div_op(op_q))
      busy_res = is_rem_op(op_q) ? rem_fix : quo_fix;
    else
      busy_res = is_high_op(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (special || fast_mul) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= MUL;
      neg_q    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      prem     <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= res_neg;
      cnt   <= CNT_INIT;
      prem  <= '0;
      if (is_div_op(op)) begin
        mcand <= op2_mag;
        acc   <= {{XLEN{1'b0}}, op1_mag};
      end else begin
        mcand <= op1_mag;
        acc   <= {{XLEN{1'b0}}, op2_mag};
      end
      if (special)       result_q <= special_res;
      else if (fast_mul) result_q <= fast_res;
    end else if ((state == BUSY) && !kill) begin
      cnt <= cnt - CW'(1);
      if (is_div_op(op_q)) begin
        acc  <= {acc[2*XLEN-1:XLEN], q_next};
        prem <= div_rem_next;
      end else begin
        acc <= mul_next;
      end
      if (cnt == '0) result_q <= busy_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  muldiv_op_t      op = MUL;
  logic [XLEN-1:0] op1_data = '0;
  logic [XLEN-1:0] op2_data = '0;
  logic            kill = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1_data  (op1_data),
    .op2_data  (op2_data),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after an edge with the unit in IDLE; accept happens at the next edge.
  task automatic issue(input muldiv_op_t o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op       = o;
    op1_data = a;
    op2_data = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (T+n) at which out_valid is first seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input muldiv_op_t o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_lat);
    int lat;
    issue(o, a, b);
    wait_out(lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, result, exp_res);
    take_out(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_result", result, 32'h0);

    // kill wins over in_valid in IDLE: nothing is accepted
    op = DIVU; op1_data = 32'd9; op2_data = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check_val("kill_idle_ready", in_ready, 1'b1);
    check_val("kill_idle_valid", out_valid, 1'b0);

    run_op("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mul_big", MUL,   32'h0001_0003, 32'h0002_0005, 32'h000B_000F, MUL_LAT);
    run_op("div",    DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",   DIVU,   32'd100,      32'd7,        32'd14,        DIV_LAT);
    run_op("remu",   REMU,   32'd100,      32'd7,        32'd2,         DIV_LAT);
    run_op("div0",   DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, SPC_LAT);
    run_op("rem0",   REM,    32'd5,        32'd0,        32'd5,         SPC_LAT);
    run_op("divovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_op("removf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       SPC_LAT);

    // Backpressure: result held and in_ready low while DONE waits
    begin
      int lat;
      issue(DIVU, 32'd100, 32'd7);
      wait_out(lat);
      check_val("bp_lat", lat, DIV_LAT);
      for (int i = 0; i < 5; i++) begin
        check_val("bp_hold_res", result, 32'd14);
        check_val("bp_hold_ready", in_ready, 1'b0);
        check_val("bp_hold_valid", out_valid, 1'b1);
        @(posedge clk); #1;
      end
      take_out("bp");
      check_val("bp_valid_drop", out_valid, 1'b0);
    end

    // kill on the 10th BUSY cycle
    issue(DIVU, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_val("kill_busy_ready", in_ready, 1'b1);
    check_val("kill_busy_valid", out_valid, 1'b0);
    repeat (40) @(posedge clk);
    #1 check_val("kill_no_late_valid", out_valid, 1'b0);
    run_op("after_kill", DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

    // Same sequence using reset instead of kill
    issue(DIVU, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_busy_ready", in_ready, 1'b1);
    check_val("rst_busy_valid", out_valid, 1'b0);
    check_val("rst_busy_result", result, 32'h0);
    run_op("after_rst", DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
